// File: rtl/data_memory_port.sv
// rtl/data_memory_port.sv - initiator side of the CPU data-memory interface
// One load or store per request; out-of-range addresses fault without touching memory.
module data_memory_port #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WORD_SIZE-1:0] resp_data,
  output logic                 resp_fault,
  output logic [WORD_SIZE-1:0] memaddr,
  output logic [WORD_SIZE-1:0] memval,
  output logic                 memget,
  output logic                 memset,
  input  logic [WORD_SIZE-1:0] memout
);

  typedef enum logic [2:0] {
    IDLE,
    STORE,
    LOAD,
    LOAD_WAIT,
    RESP
  } state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0] val_q, val_d;
  logic [WORD_SIZE-1:0] rdata_q, rdata_d;
  logic                 fault_q, fault_d;
  logic                 accept;
  logic                 addr_fault;

  assign accept     = (state_q == IDLE) && ready_q && req_valid;
  assign addr_fault = |req_addr[WORD_SIZE-1:ADDR_BITS];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    val_d   = val_q;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          rdata_d = '0;
          fault_d = addr_fault;
          if (addr_fault) begin
            state_d = RESP;
          end else if (req_write) begin
            addr_d  = req_addr;
            val_d   = req_data;
            state_d = STORE;
          end else begin
            addr_d  = req_addr;
            state_d = LOAD;
          end
        end
      end
      STORE:     state_d = RESP;
      LOAD:      state_d = LOAD_WAIT;
      LOAD_WAIT: begin
        // Memory registers its read on the LOAD->LOAD_WAIT edge, so memout is valid here.
        rdata_d = memout;
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default:   state_d = IDLE;
    endcase
    // Registered so req_ready reads 0 for the whole reset assertion.
    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      val_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      addr_q  <= addr_d;
      val_q   <= val_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == RESP);
  assign resp_data  = rdata_q;
  assign resp_fault = fault_q;
  assign memaddr    = addr_q;
  assign memval     = val_q;
  assign memget     = (state_q == LOAD);
  assign memset     = (state_q == STORE);

endmodule

// File: tb/tb_data_memory_port.sv
// tb/tb_data_memory_port.sv - self-checking bench for data_memory_port
// Table of directed requests plus hand sequences for backpressure and reset-in-store.
module tb_data_memory_port;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [15:0] data;
    logic        exp_fault;
    logic [15:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr, req_data;
  logic        resp_valid, resp_ready, resp_fault;
  logic [15:0] resp_data;
  logic [15:0] memaddr, memval, memout;
  logic        memget, memset;

  logic [15:0] mem [0:1023];
  int          cyc = 0;
  int          set_cnt = 0, get_cnt = 0, both_cnt = 0;
  logic [15:0] set_addr = '0, set_val = '0, get_addr = '0;
  int          n_chk = 0, n_fail = 0;

  data_memory_port #(.WORD_SIZE(16), .ADDR_BITS(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault),
    .memaddr(memaddr), .memval(memval), .memget(memget), .memset(memset),
    .memout(memout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (memset) mem[memaddr[9:0]] <= memval;
    if (memget) memout <= mem[memaddr[9:0]];
  end

  always @(negedge clk) begin
    if (memset) begin set_cnt <= set_cnt + 1; set_addr <= memaddr; set_val <= memval; end
    if (memget) begin get_cnt <= get_cnt + 1; get_addr <= memaddr; end
    if (memset && memget) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_req(input vec_t v, output int lat, output int acc);
    int g;
    req_write = v.write;
    req_addr  = v.addr;
    req_data  = v.data;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) chk("accept_timeout", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    acc = cyc;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  vec_t vq[$];
  vec_t v;
  int   lat, acc, prev_acc, rc;
  int   s0, g0;

  initial begin
    vq.push_back('{1'b1, 16'h0005, 16'h1234, 1'b0, 16'h0000});
    vq.push_back('{1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234});
    vq.push_back('{1'b0, 16'h0400, 16'h0000, 1'b1, 16'h0000});
    vq.push_back('{1'b1, 16'h03FF, 16'hBEEF, 1'b0, 16'h0000});
    vq.push_back('{1'b0, 16'h03FF, 16'h0000, 1'b0, 16'hBEEF});
    vq.push_back('{1'b1, 16'hFFFF, 16'h5555, 1'b1, 16'h0000});
    for (int a = 0; a < 8; a++) begin
      vq.push_back('{1'b1, 16'(a), 16'(16'hC000 + a * 16'h0111), 1'b0, 16'h0000});
      vq.push_back('{1'b0, 16'(a), 16'h0000, 1'b0, 16'(16'hC000 + a * 16'h0111)});
    end

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_data = '0; resp_ready = 1'b1;
    #2;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset_strobes", {30'd0, memget, memset}, 32'd0);
    chk("reset_memaddr", {16'd0, memaddr}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", {31'd0, req_ready}, 32'd1);

    prev_acc = 0;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      s0 = set_cnt; g0 = get_cnt;
      do_req(v, lat, acc);
      chk($sformatf("v%0d_latency", i), 32'(lat),
          v.exp_fault ? 32'd0 : (v.write ? 32'd1 : 32'd2));
      chk($sformatf("v%0d_fault", i), {31'd0, resp_fault}, {31'd0, v.exp_fault});
      chk($sformatf("v%0d_data", i), {16'd0, resp_data}, {16'd0, v.exp_data});
      chk($sformatf("v%0d_memset_cnt", i), 32'(set_cnt - s0),
          32'(v.write && !v.exp_fault));
      chk($sformatf("v%0d_memget_cnt", i), 32'(get_cnt - g0),
          32'(!v.write && !v.exp_fault));
      if (v.write && !v.exp_fault) begin
        chk($sformatf("v%0d_set_addr", i), {16'd0, set_addr}, {16'd0, v.addr});
        chk($sformatf("v%0d_set_val", i), {16'd0, set_val}, {16'd0, v.data});
      end
      if (!v.write && !v.exp_fault)
        chk($sformatf("v%0d_get_addr", i), {16'd0, get_addr}, {16'd0, v.addr});
      if (i > 0)
        chk($sformatf("v%0d_interval", i), 32'(acc - prev_acc),
            vq[i-1].exp_fault ? 32'd2 : (vq[i-1].write ? 32'd3 : 32'd4));
      prev_acc = acc;
    end
    @(posedge clk); #1;
    chk("drain_resp_valid", {31'd0, resp_valid}, 32'd0);

    // Backpressure: response held 5 cycles, stray store ignored meanwhile.
    resp_ready = 1'b0;
    do_req('{1'b0, 16'h0005, 16'h0000, 1'b0, 16'hC555}, lat, acc);
    chk("bp_latency", 32'(lat), 32'd2);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0005; req_data = 16'hDEAD;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_resp_valid", k), {31'd0, resp_valid}, 32'd1);
      chk($sformatf("bp%0d_resp_data", k), {16'd0, resp_data}, 32'h0000C555);
      chk($sformatf("bp%0d_req_ready", k), {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    rc = cyc;
    s0 = set_cnt;
    do_req('{1'b0, 16'h0005, 16'h0000, 1'b0, 16'hC555}, lat, acc);
    chk("bp_accept_cycle", 32'(acc - rc), 32'd2);
    chk("bp_reload_data", {16'd0, resp_data}, 32'h0000C555);
    chk("bp_no_stray_store", 32'(set_cnt - s0), 32'd0);
    @(posedge clk); #1;

    // Reset while memset is high: store lost, outputs cleared at once.
    req_write = 1'b1; req_addr = 16'h0005; req_data = 16'h7777; req_valid = 1'b1;
    rc = 0;
    while (!req_ready && rc < 50) begin @(negedge clk); rc++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_memset_before", {31'd0, memset}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_memset_async", {31'd0, memset}, 32'd0);
    chk("rst_memaddr", {16'd0, memaddr}, 32'd0);
    chk("rst_memval", {16'd0, memval}, 32'd0);
    chk("rst_resp", {14'd0, resp_valid, resp_fault, resp_data}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
    do_req('{1'b0, 16'h0005, 16'h0000, 1'b0, 16'hC555}, lat, acc);
    chk("rst_old_contents", {16'd0, resp_data}, 32'h0000C555);
    chk("rst_load_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    chk("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
